axis2ibuf: RTL and testbench

- Ingress stage that writes packets from a 64-bit AXI-Stream source into the ibuf dual-port RAM that the backend sender reads.
- Per packet: one header qword (byte length in [47:32]), then ceil(len/8) data qwords.
- Publishes a wrapping write pointer, committed_prod, only once a packet's data and header are both in RAM.
- Consumes committed_cons for free-space flow control.

---
 rtl/axis2ibuf.sv | 152 +++++++++++++++
 tb/tb_axis2ibuf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axis2ibuf.sv
// AXI-Stream to ibuf ring writer: data qwords first, header last, then commit of the producer pointer.
// RAM writes lag acceptance by one cycle; tready drops when the ring is full and during header/commit/rewind.
module axis2ibuf #(
  parameter int BW      = 9,
  parameter int MAX_LEN = 1518
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   s_axis_tdata,
  input  logic [7:0]    s_axis_tstrb,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready,
  output logic [BW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          wr_en,
  output logic [BW:0]   committed_prod,
  input  logic [BW:0]   committed_cons,
  output logic [31:0]   drop_cnt
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_DATA,
    ST_HDR,
    ST_COMMIT,
    ST_DROP,
    ST_REWIND
  } state_t;

  state_t          state, state_nxt;
  logic [BW:0]     hdr_ptr, hdr_ptr_nxt;
  logic [BW:0]     wr_ptr, wr_ptr_nxt;
  logic [BW:0]     cons_q;
  logic [BW:0]     occ;
  logic [BW:0]     prod_nxt;
  logic [16:0]     byte_cnt, byte_cnt_nxt, new_cnt;
  logic [31:0]     drop_nxt;
  logic            wr_en_nxt;
  logic [BW-1:0]   wr_addr_nxt;
  logic [63:0]     wr_data_nxt;
  logic [3:0]      strb_bytes;
  logic            bad_beat;
  logic            room;

  // Header slot is already inside wr_ptr, so occupancy covers it too.
  assign occ  = wr_ptr - cons_q;
  assign room = ~occ[BW];

  always_comb begin
    strb_bytes = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (s_axis_tstrb[i] && (strb_bytes == 4'(i))) begin
        strb_bytes = 4'(i + 1);
      end
    end
  end

  assign new_cnt  = byte_cnt + (s_axis_tlast ? {13'd0, strb_bytes} : 17'd8);
  assign bad_beat = (new_cnt > 17'(MAX_LEN))
                  || (s_axis_tlast && (s_axis_tstrb == 8'h00))
                  || (!s_axis_tlast && (s_axis_tstrb != 8'hFF));

  always_comb begin
    state_nxt     = state;
    hdr_ptr_nxt   = hdr_ptr;
    wr_ptr_nxt    = wr_ptr;
    byte_cnt_nxt  = byte_cnt;
    prod_nxt      = committed_prod;
    drop_nxt      = drop_cnt;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    s_axis_tready = 1'b0;
    case (state)
      ST_INIT: begin
        hdr_ptr_nxt  = committed_prod;
        wr_ptr_nxt   = committed_prod + 1'b1;
        byte_cnt_nxt = '0;
        state_nxt    = ST_DATA;
      end
      ST_DATA: begin
        s_axis_tready = room;
        if (s_axis_tvalid && room) begin
          wr_en_nxt    = 1'b1;
          wr_addr_nxt  = wr_ptr[BW-1:0];
          wr_data_nxt  = s_axis_tdata;
          wr_ptr_nxt   = wr_ptr + 1'b1;
          byte_cnt_nxt = new_cnt;
          if (bad_beat) begin
            state_nxt = s_axis_tlast ? ST_REWIND : ST_DROP;
          end else if (s_axis_tlast) begin
            state_nxt = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = hdr_ptr[BW-1:0];
        wr_data_nxt = {16'd0, byte_cnt[15:0], 32'd0};
        state_nxt   = ST_COMMIT;
      end
      ST_COMMIT: begin
        prod_nxt     = wr_ptr;
        hdr_ptr_nxt  = wr_ptr;
        wr_ptr_nxt   = wr_ptr + 1'b1;
        byte_cnt_nxt = '0;
        state_nxt    = ST_DATA;
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = ST_REWIND;
        end
      end
      ST_REWIND: begin
        drop_nxt     = (drop_cnt == 32'hFFFF_FFFF) ? drop_cnt : drop_cnt + 32'd1;
        wr_ptr_nxt   = hdr_ptr + 1'b1;
        byte_cnt_nxt = '0;
        state_nxt    = ST_DATA;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_INIT;
      hdr_ptr        <= '0;
      wr_ptr         <= '0;
      cons_q         <= '0;
      byte_cnt       <= '0;
      committed_prod <= '0;
      drop_cnt       <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
    end else begin
      state          <= state_nxt;
      hdr_ptr        <= hdr_ptr_nxt;
      wr_ptr         <= wr_ptr_nxt;
      cons_q         <= committed_cons;
      byte_cnt       <= byte_cnt_nxt;
      committed_prod <= prod_nxt;
      drop_cnt       <= drop_nxt;
      wr_en          <= wr_en_nxt;
      wr_addr        <= wr_addr_nxt;
      wr_data        <= wr_data_nxt;
    end
  end

endmodule

// File: tb/tb_axis2ibuf.sv
// Directed bench: a 512-slot instance for framing/drop/reset and a 16-slot instance for full-ring and wrap.
module tb_axis2ibuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0]  tstrb = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        sel = 1'b0;

  logic        tvalid_a, rdy_a, wr_en_a;
  logic [8:0]  wr_addr_a;
  logic [63:0] wr_data_a;
  logic [9:0]  prod_a;
  logic [9:0]  cons_a = '0;
  logic [31:0] drop_a;

  logic        tvalid_b, rdy_b, wr_en_b;
  logic [3:0]  wr_addr_b;
  logic [63:0] wr_data_b;
  logic [4:0]  prod_b;
  logic [4:0]  cons_b = '0;
  logic [31:0] drop_b;

  logic        rdy;
  logic [63:0] mem_a [512];
  logic [63:0] mem_b [16];
  int          wcnt_a = 0;
  int          wcnt_b = 0;
  int          lowcnt_b = 0;
  int          vectors = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  assign tvalid_a = tvalid & ~sel;
  assign tvalid_b = tvalid & sel;
  assign rdy      = sel ? rdy_b : rdy_a;

  axis2ibuf #(.BW(9), .MAX_LEN(1518)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tvalid(tvalid_a),
    .s_axis_tlast(tlast), .s_axis_tready(rdy_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a),
    .committed_prod(prod_a), .committed_cons(cons_a), .drop_cnt(drop_a)
  );

  axis2ibuf #(.BW(4), .MAX_LEN(112)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tstrb(tstrb), .s_axis_tvalid(tvalid_b),
    .s_axis_tlast(tlast), .s_axis_tready(rdy_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b),
    .committed_prod(prod_b), .committed_cons(cons_b), .drop_cnt(drop_b)
  );

  always @(posedge clk) begin
    if (wr_en_a) begin
      mem_a[wr_addr_a] <= wr_data_a;
      wcnt_a <= wcnt_a + 1;
    end
    if (wr_en_b) begin
      mem_b[wr_addr_b] <= wr_data_b;
      wcnt_b <= wcnt_b + 1;
      if (wr_addr_b < 4'd6) lowcnt_b <= lowcnt_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    @(negedge clk);
    tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(rdy), 64'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [31:0] tag);
    int nb = (len + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      logic [7:0] s;
      s = 8'hFF;
      if ((i == nb - 1) && (len % 8 != 0)) s = 8'((1 << (len % 8)) - 1);
      beat({tag, 32'(i)}, s, i == nb - 1);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w0, low0, hdr, expp;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(rdy_a), 64'd0);
    chk("rst_wr_en", 64'(wr_en_a), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr_a), 64'd0);
    chk("rst_wr_data", wr_data_a, 64'd0);
    chk("rst_prod", 64'(prod_a), 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);
    chk("rst_prod_b", 64'(prod_b), 64'd0);
    rst = 1'b0;

    // Reset in the middle of a packet
    for (int i = 0; i < 3; i++) beat({32'hDEAD, 32'(i)}, 8'hFF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tready", 64'(rdy_a), 64'd0);
    chk("midrst_wr_en", 64'(wr_en_a), 64'd0);
    chk("midrst_prod", 64'(prod_a), 64'd0);
    chk("midrst_drop", 64'(drop_a), 64'd0);
    rst = 1'b0;

    // 64-byte packet: data at 1..8, header at 0, commit one cycle after header
    send_pkt(64, 32'hA0);
    @(negedge clk);
    chk("p64_last_addr", 64'(wr_addr_a), 64'd8);
    @(negedge clk);
    chk("p64_hdr_en", 64'(wr_en_a), 64'd1);
    chk("p64_hdr_addr", 64'(wr_addr_a), 64'd0);
    chk("p64_hdr_data", wr_data_a, 64'h0000_0040_0000_0000);
    chk("p64_prod_early", 64'(prod_a), 64'd0);
    @(negedge clk);
    chk("p64_prod", 64'(prod_a), 64'd9);
    chk("p64_idle_en", 64'(wr_en_a), 64'd0);
    for (int i = 0; i < 8; i++) chk("p64_data", mem_a[i + 1], {32'hA0, 32'(i)});
    cons_a = 10'd9;

    // 61-byte packet, partial last beat
    send_pkt(61, 32'hB0);
    settle(3);
    chk("p61_hdr", mem_a[9], 64'h0000_003D_0000_0000);
    chk("p61_prod", 64'(prod_a), 64'd18);
    chk("p61_last", mem_a[17], {32'hB0, 32'd7});
    cons_a = 10'd18;

    // Oversize packet dropped, then next packet reuses the header slot
    w0 = wcnt_a;
    send_pkt(1600, 32'hC0);
    settle(3);
    chk("big_writes", 64'(wcnt_a - w0), 64'd190);
    chk("big_drop", 64'(drop_a), 64'd1);
    chk("big_prod", 64'(prod_a), 64'd18);
    send_pkt(64, 32'hD0);
    settle(3);
    chk("after_drop_hdr", mem_a[18], 64'h0000_0040_0000_0000);
    chk("after_drop_data", mem_a[19], {32'hD0, 32'd0});
    chk("after_drop_prod", 64'(prod_a), 64'd27);

    // Full ring on the 16-slot instance with cons held at 0
    sel = 1'b1;
    send_pkt(40, 32'hE1);
    settle(3);
    chk("ring_prod1", 64'(prod_b), 64'd6);
    send_pkt(40, 32'hE2);
    settle(3);
    chk("ring_prod2", 64'(prod_b), 64'd12);
    chk("ring_hdr2", mem_b[6], 64'h0000_0028_0000_0000);
    low0 = lowcnt_b;
    for (int i = 0; i < 3; i++) beat({32'hE3, 32'(i)}, 8'hFF, 1'b0);
    @(negedge clk);
    tdata = {32'hE3, 32'd3}; tstrb = 8'hFF; tlast = 1'b0; tvalid = 1'b1;
    settle(4);
    w0 = wcnt_b;
    settle(6);
    chk("full_tready", 64'(rdy_b), 64'd0);
    chk("full_no_write", 64'(wcnt_b - w0), 64'd0);
    chk("full_low_untouched", 64'(lowcnt_b - low0), 64'd0);
    cons_b = 5'd6;
    beat({32'hE3, 32'd3}, 8'hFF, 1'b0);
    beat({32'hE3, 32'd4}, 8'hFF, 1'b1);
    settle(3);
    chk("resume_prod", 64'(prod_b), 64'd18);
    chk("resume_addr0", mem_b[0], {32'hE3, 32'd3});
    chk("resume_hdr", mem_b[12], 64'h0000_0028_0000_0000);
    chk("resume_low_writes", 64'(lowcnt_b - low0), 64'd2);

    // Wrap with cons following prod
    cons_b = 5'd18;
    for (int k = 0; k < 5; k++) begin
      hdr  = (18 + 4 * k) % 32;
      expp = (22 + 4 * k) % 32;
      send_pkt(24, 32'hF0 + 32'(k));
      settle(3);
      chk("wrap_prod", 64'(prod_b), 64'(expp));
      chk("wrap_hdr", mem_b[hdr % 16], 64'h0000_0018_0000_0000);
      cons_b = 5'(expp);
    end
    chk("wrap_data_addr0", mem_b[0], {32'hF3, 32'd1});
    chk("wrap_prod_msb", 64'(prod_b[4]), 64'd0);
    chk("wrap_drop_b", 64'(drop_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
